// File: rtl/local_mem_req_adapter_if.sv
// local_mem_req_adapter_if
//   Bundles the three sides of the adapter into one interface:
//   core-side request channel, core-side read-response channel and the
//   one-cycle-latency local memory port.
//   Parameter AW: memory word-address width ($clog2(RAM_SIZE*256)).
//   Signals:
//     req_valid/req_ready      request handshake
//     req_addr/req_we/req_be/req_wdata   request payload (byte address)
//     rsp_valid/rsp_ready/rsp_rdata      read-response handshake and data
//     mem_addr/mem_en/mem_be/mem_data_in memory port controls and write data
//     mem_data_out             memory read data (one cycle after mem_en)
//     addr_err                 out-of-range request pulse
//   Modports: slave = adapter side, master = requester/memory side.
interface local_mem_req_adapter_if #(
  parameter int AW = 14
) ();
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          req_we;
  logic [3:0]    req_be;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic [3:0]    mem_be;
  logic [31:0]   mem_data_in;
  logic [31:0]   mem_data_out;
  logic          addr_err;

  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_wdata, rsp_ready, mem_data_out,
    output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_en, mem_be, mem_data_in, addr_err
  );

  modport master (
    output req_valid, req_addr, req_we, req_be, req_wdata, rsp_ready, mem_data_out,
    input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_en, mem_be, mem_data_in, addr_err
  );
endinterface

// File: rtl/local_mem_req_adapter.sv
// local_mem_req_adapter
//   Converts a valid/ready load/store request stream into the local memory's
//   fixed one-cycle-latency en/be/addr port. Reads are tracked while in flight
//   and their data lands either straight on the response port (bypass) or in
//   a small circular response buffer, so a stalled consumer never loses data.
//   A credit scheme (buffer slots minus buffered and in-flight reads) throttles
//   req_ready so the buffer can never overflow; responses stay in order.
//   Parameters: RAM_SIZE (KB, word address width derived), RSP_DEPTH (>=2).
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-low reset
//     bus  local_mem_req_adapter_if.slave (request, response, memory port)
//   Optional feature macro: LOCAL_MEM_ADAPTER_ADDR_CHECK_EN
//     defined   - requests above the memory size are accepted but do not
//                 touch memory; addr_err pulses and reads return 32'h0.
//     undefined - upper address bits are ignored (address wraps), addr_err=0.
module local_mem_req_adapter #(
  parameter int RAM_SIZE  = 64,
  parameter int RSP_DEPTH = 2
) (
  input logic                    clk,
  input logic                    rst,
  local_mem_req_adapter_if.slave bus
);
  localparam int LINES = RAM_SIZE * 256;
  localparam int AW    = $clog2(LINES);
  localparam int CW    = $clog2(RSP_DEPTH + 1);
  localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic          r_inflight;
  logic          r_inflightZero;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [31:0]   r_buf [RSP_DEPTH];

  logic        w_addrBad;
  logic        w_hasCredit;
  logic        w_rspValid;
  logic        w_accept;
  logic        w_read;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_inflightData;
  logic        w_unused;

  function automatic logic [PW-1:0] ptrNext(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef LOCAL_MEM_ADAPTER_ADDR_CHECK_EN
  assign w_addrBad = |bus.req_addr[31:AW+2];
`else
  assign w_addrBad = 1'b0;
`endif

  // Byte-offset bits never matter; upper bits only matter with the range check.
  assign w_unused = ^{bus.req_addr[1:0], bus.req_addr[31:AW+2]};

  // A credit exists while buffered plus in-flight reads leave a free slot; a
  // pop happening this cycle frees a slot as well.
  assign w_rspValid    = r_inflight | (r_count != '0);
  assign w_hasCredit   = (int'(r_count) + int'(r_inflight)) < RSP_DEPTH;
  assign bus.req_ready = w_hasCredit | (w_rspValid & bus.rsp_ready);
  assign bus.rsp_valid = w_rspValid;

  // Accept is blocked while reset is held so the memory port stays quiet.
  assign w_accept        = bus.req_valid & bus.req_ready & rst;
  assign w_read          = w_accept & ~bus.req_we;
  assign bus.mem_en      = w_accept & ~w_addrBad;
  assign bus.addr_err    = w_accept & w_addrBad;
  assign bus.mem_addr    = bus.req_addr[AW+1:2];
  assign bus.mem_be      = bus.req_we ? bus.req_be : 4'b0000;
  assign bus.mem_data_in = bus.req_wdata;

  // Out-of-range reads never touched memory, so their response is forced to zero.
  assign w_inflightData = r_inflightZero ? 32'h0 : bus.mem_data_out;

  // Bypass only happens when nothing older is buffered and the consumer takes it;
  // every other arriving read word is queued at the tail.
  assign w_push = r_inflight & ~((r_count == '0) & bus.rsp_ready);
  assign w_pop  = (r_count != '0) & bus.rsp_ready;

  // Response data: oldest buffered entry first, else the word arriving from memory.
  always_comb begin
    bus.rsp_rdata = 32'h0;
    if (r_count != '0) begin
      bus.rsp_rdata = r_buf[r_head];
    end else if (r_inflight) begin
      bus.rsp_rdata = w_inflightData;
    end
  end

  // Control state: in-flight flag, occupancy and circular pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_inflight     <= 1'b0;
      r_inflightZero <= 1'b0;
      r_count        <= '0;
      r_head         <= '0;
      r_tail         <= '0;
    end else begin
      r_inflight     <= w_read;
      r_inflightZero <= w_read & w_addrBad;
      if (w_push) begin
        r_tail <= ptrNext(r_tail);
      end
      if (w_pop) begin
        r_head <= ptrNext(r_head);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer storage needs no reset: occupancy decides what is ever presented.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf[r_tail] <= w_inflightData;
    end
  end

  // The credit rule must keep a slot free for every in-flight read.
  assert property (@(posedge clk) disable iff (!rst)
    !(w_push && !w_pop && (r_count == CW'(RSP_DEPTH))));

endmodule
